// File: rtl/afpm_op_scheduler.sv
// Round-robin sequencer in front of the byte-serial log FP16 multiplier core.
// Optional macro AFPM_ZERO_BYPASS_EN: zero-magnitude operands skip the core.
module afpm_op_scheduler #(
    parameter int CORE_LATENCY = 2,
    parameter int CNT_W        = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [15:0] req0_a,
    input  logic [15:0] req0_b,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [15:0] req1_a,
    input  logic [15:0] req1_b,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
    output logic [15:0] rsp_data,
    output logic [7:0]  core_a_byte,
    output logic [7:0]  core_b_byte,
    output logic        core_load,
    input  logic [7:0]  core_res_byte,
    output logic        busy
);

    typedef enum logic [2:0] {
        IDLE, SEND_LO, SEND_HI, WAIT, RECV_LO, RECV_HI, RESP
    } state_t;

    state_t            state;
    state_t            next_state;
    logic [15:0]       op_a;
    logic [15:0]       op_b;
    logic [15:0]       result;
    logic              op_id;
    logic              prio;
    logic [CNT_W-1:0]  cnt;
    logic              any_valid;
    logic              grant;
    logic              bypass;
    logic [15:0]       sel_a;
    logic [15:0]       sel_b;

    // With both requesters valid the priority pointer decides; otherwise the lone one wins.
    always_comb begin
        any_valid = req0_valid | req1_valid;
        grant     = (req0_valid && req1_valid) ? prio : req1_valid;
        sel_a     = grant ? req1_a : req0_a;
        sel_b     = grant ? req1_b : req0_b;
`ifdef AFPM_ZERO_BYPASS_EN
        bypass    = (sel_a[14:0] == 15'd0) || (sel_b[14:0] == 15'd0);
`else
        bypass    = 1'b0;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (any_valid) next_state = bypass ? RESP : SEND_LO;
            SEND_LO: next_state = SEND_HI;
            SEND_HI: next_state = (CORE_LATENCY == 0) ? RECV_LO : WAIT;
            WAIT:    if (cnt == CNT_W'(1)) next_state = RECV_LO;
            RECV_LO: next_state = RECV_HI;
            RECV_HI: next_state = RESP;
            RESP:    if (rsp_ready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Operand latch, wait counter, result assembly and round-robin pointer.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_a   <= 16'd0;
            op_b   <= 16'd0;
            op_id  <= 1'b0;
            prio   <= 1'b0;
            result <= 16'd0;
            cnt    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_valid) begin
                        op_a   <= sel_a;
                        op_b   <= sel_b;
                        op_id  <= grant;
                        result <= bypass ? {sel_a[15] ^ sel_b[15], 15'd0} : 16'd0;
                    end
                end
                SEND_HI: cnt <= CNT_W'(CORE_LATENCY);
                WAIT:    cnt <= cnt - CNT_W'(1);
                RECV_LO: result[7:0]  <= core_res_byte;
                RECV_HI: result[15:8] <= core_res_byte;
                RESP: begin
                    if (rsp_ready) prio <= ~op_id;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        req0_ready  = (state == IDLE) && req0_valid && !grant;
        req1_ready  = (state == IDLE) && req1_valid && grant;
        busy        = (state != IDLE);
        core_load   = 1'b0;
        core_a_byte = 8'd0;
        core_b_byte = 8'd0;
        rsp_valid   = 1'b0;
        rsp_data    = 16'd0;
        rsp_id      = 1'b0;
        case (state)
            SEND_LO: begin
                core_load   = 1'b1;
                core_a_byte = op_a[7:0];
                core_b_byte = op_b[7:0];
            end
            SEND_HI: begin
                core_load   = 1'b1;
                core_a_byte = op_a[15:8];
                core_b_byte = op_b[15:8];
            end
            RESP: begin
                rsp_valid = 1'b1;
                rsp_data  = result;
                rsp_id    = op_id;
            end
            default: ;
        endcase
    end

endmodule

// File: doc/afpm_op_scheduler.md
Name: afpm_op_scheduler

Overview:
Sequencer and arbiter in front of the byte-serial logarithmic FP16 multiplier core.
- Accepts complete 16-bit operand pairs from two requesters over valid/ready handshakes and arbitrates between them round-robin.
- Serializes the granted pair into the core's 8-bit lanes, low byte first, then waits the core latency.
- Reassembles the 16-bit product from the core's byte output and returns it, tagged with the requester ID, over a valid/ready response port.

Parameters:
- CORE_LATENCY, default 2: cycles between the second (high) operand byte and the first (low) result byte at the core; legal range 0..15.
- CNT_W, default 4: width of the wait counter; must satisfy 2^CNT_W > CORE_LATENCY.

Ports:
- clk  input  1  system clock; all logic is rising-edge.
- rst  input  1  synchronous reset, active-high.
- req0_valid  input  1  requester 0 has an operand pair.
- req0_ready  output  1  requester 0 pair accepted this cycle.
- req0_a  input  16  requester 0 operand A (FP16).
- req0_b  input  16  requester 0 operand B (FP16).
- req1_valid  input  1  requester 1 has an operand pair.
- req1_ready  output  1  requester 1 pair accepted this cycle.
- req1_a  input  16  requester 1 operand A.
- req1_b  input  16  requester 1 operand B.
- rsp_valid  output  1  product available.
- rsp_ready  input  1  consumer takes the product.
- rsp_id  output  1  requester that owns rsp_data.
- rsp_data  output  16  FP16 product.
- core_a_byte  output  8  operand A byte lane to the core.
- core_b_byte  output  8  operand B byte lane to the core.
- core_load  output  1  lane bytes valid this cycle.
- core_res_byte  input  8  result byte lane from the core.
- busy  output  1  high in every state except IDLE.

Behaviour:
- Reset (rst=1 at a clock edge):
  - state returns to IDLE.
  - All outputs go to 0: ready, rsp_*, core_*, busy.
  - Priority pointer is set to requester 0.
  - Latched operands, result and counter are cleared.
  - Reset mid-transaction aborts it silently; no response is produced for the aborted pair.
- States: IDLE, SEND_LO, SEND_HI, WAIT, RECV_LO, RECV_HI, RESP.
- IDLE:
  - reqN_ready is combinational: high only when state==IDLE, reqN_valid=1 and N is granted.
  - Grant:
    - Only one requester valid: that requester wins.
    - Both valid: the requester selected by the priority pointer wins.
  - On accept, latch A, B and ID and go to SEND_LO.
  - Nothing valid: stay in IDLE.
- SEND_LO: core_load=1, core_a_byte=A[7:0], core_b_byte=B[7:0]; next state SEND_HI.
- SEND_HI: core_load=1, A[15:8]/B[15:8]; counter loaded with CORE_LATENCY.
  - CORE_LATENCY==0: next state RECV_LO.
  - Otherwise: next state WAIT.
- WAIT: counter decrements each cycle; at the cycle it reaches 1, next state RECV_LO. Stays exactly CORE_LATENCY cycles.
- RECV_LO: capture core_res_byte into result[7:0].
- RECV_HI: capture core_res_byte into result[15:8].
- RESP:
  - rsp_valid=1; rsp_data and rsp_id are held stable until rsp_ready=1.
  - On rsp_ready=1: go to IDLE, drop rsp_valid the next cycle, and point the priority pointer at the requester NOT just served.
  - rsp_ready high while rsp_valid is low has no effect.
- Timing (accept at cycle T):
  - SEND_LO at T+1.
  - rsp_valid first high at T+5+CORE_LATENCY.
  - With rsp_ready tied high, the next accept is possible at T+6+CORE_LATENCY.
- core_load=0 and byte lanes=0 outside SEND_LO/SEND_HI.
- Requester inputs are ignored outside IDLE; the pair is latched, so requesters may change their inputs after accept.
- One transaction in flight; no overlap.

Optional Feature:
- Macro AFPM_ZERO_BYPASS_EN.
- When defined:
  - In IDLE, if the accepted pair has A[14:0]==0 or B[14:0]==0, skip the core: next state is RESP with rsp_data={A[15]^B[15],15'b0}.
  - rsp_valid goes high at T+1; core_load stays 0.
  - Round-robin update rules are unchanged.
- When undefined: every pair goes through the core unconditionally.

Test Plan:
- CORE_LATENCY=2, stub core returns 0x4480; req0 A=0x3E00 B=0x4200 -> req0_ready at T; core_load at T+1 (bytes 0x00/0x00) and T+2 (bytes 0x3E/0x42); rsp_valid at T+7 with rsp_data=0x4480, rsp_id=0.
- Both requesters valid continuously, rsp_ready=1 -> grants alternate 0,1,0,1 across four transactions; rsp_id follows the same sequence.
- rsp_ready held low 5 cycles in RESP -> rsp_valid, rsp_data and rsp_id stable for all 5 cycles; no new req ready asserted until 1 cycle after rsp_ready=1.
- rst asserted during WAIT -> next cycle busy=0, rsp_valid=0, core_load=0; a subsequent req1 A=0x3C00 B=0x3C00 completes normally with rsp_id=1.
- CORE_LATENCY=0 build -> rsp_valid at T+5; result bytes are sampled in the cycles directly after SEND_HI.
- AFPM_ZERO_BYPASS_EN defined; A=0x8000 B=0x4200 -> rsp_valid at T+1, rsp_data=0x8000, core_load never high. Without the macro the same pair goes through the core.
